// File: rtl/pulser_pkg.sv
// Shared constants for the pulser channel: mode codes, FSM state encoding
// and default counter widths.
package pulser_pkg;

    localparam int CW_DEFAULT = 32;
    localparam int NW_DEFAULT = 16;

    localparam logic [1:0] MODE_SINGLE     = 2'b00;
    localparam logic [1:0] MODE_BURST      = 2'b01;
    localparam logic [1:0] MODE_CONTINUOUS = 2'b10;
    localparam logic [1:0] MODE_GATED      = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one FSM phase. Loading L makes expire assert
// on the L-th clock edge after the load edge (L must be >= 1).
module phase_timer
    import pulser_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Parks at 0 once expired, so an idle timer never re-fires.
    assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulser channel: delayed single pulse, N-pulse burst, free-running or gated
// pulse train. Timing inputs are captured at acceptance and held until the end.
module pulse_burst_gen
    import pulser_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger_in,
    input  logic          abort,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] period,
    input  logic [NW-1:0] count,
    input  logic [1:0]    mode,
    output logic          pulse_out,
    output logic          running,
    output logic          done,
    output logic [NW-1:0] pulse_idx
);

    logic [1:0]    state_reg,   state_next;
    logic          pulse_reg,   pulse_next;
    logic          running_reg, running_next;
    logic          done_reg,    done_next;
    logic [NW-1:0] idx_reg,     idx_next;
    logic [CW-1:0] width_reg,   width_next;
    logic [CW-1:0] low_reg,     low_next;
    logic [NW-1:0] last_reg,    last_next;
    logic [1:0]    mode_reg,    mode_next;

    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic          timer_expire;

    logic [CW-1:0] cur_w;
    logic [CW-1:0] cur_low;
    logic [NW-1:0] cur_last;
    logic [1:0]    cur_mode;
    logic [NW-1:0] idx_new;
    logic          begin_pulse;
    logic          end_pulse;
    logic          is_last;

    // LOW length = max(period, width+1) - width, formed without ever computing width+1.
    function automatic logic [CW-1:0] low_len(input logic [CW-1:0] p, input logic [CW-1:0] w);
        return (p > w) ? (p - w) : CW'(1);
    endfunction

    phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    // In IDLE a D=0 acceptance starts pulse 0 on the same edge, so the live
    // inputs stand in for the shadow registers that are being loaded.
    always_comb begin
        if (state_reg == ST_IDLE) begin
            cur_w    = width;
            cur_low  = low_len(period, width);
            cur_last = (count == '0) ? '0 : (count - NW'(1));
            cur_mode = mode;
        end else begin
            cur_w    = width_reg;
            cur_low  = low_reg;
            cur_last = last_reg;
            cur_mode = mode_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pulse_next   = pulse_reg;
        running_next = running_reg;
        done_next    = 1'b0;
        idx_next     = idx_reg;
        width_next   = width_reg;
        low_next     = low_reg;
        last_next    = last_reg;
        mode_next    = mode_reg;
        timer_load   = 1'b0;
        timer_val    = '0;
        idx_new      = idx_reg;
        begin_pulse  = 1'b0;
        end_pulse    = 1'b0;
        is_last      = 1'b0;

        if (abort) begin
            state_next   = ST_IDLE;
            pulse_next   = 1'b0;
            running_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trigger_in) begin
                        width_next   = cur_w;
                        low_next     = cur_low;
                        last_next    = cur_last;
                        mode_next    = cur_mode;
                        running_next = 1'b1;
                        idx_new      = '0;
                        if (delay != '0) begin
                            state_next = ST_DELAY;
                            timer_load = 1'b1;
                            timer_val  = delay;
                        end else begin
                            begin_pulse = 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (timer_expire) begin
                        begin_pulse = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_expire) begin
                        end_pulse = 1'b1;
                    end
                end
                default: begin
                    if (timer_expire) begin
                        if (mode_reg == MODE_GATED && !trigger_in) begin
                            state_next   = ST_IDLE;
                            running_next = 1'b0;
                            done_next    = 1'b1;
                        end else begin
                            begin_pulse = 1'b1;
                            idx_new     = idx_reg + NW'(1);
                        end
                    end
                end
            endcase

            // A zero-width pulse still occupies its slot in the sequence.
            if (begin_pulse) begin
                if (cur_w != '0) begin
                    state_next = ST_HIGH;
                    pulse_next = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = cur_w;
                end else begin
                    end_pulse = 1'b1;
                end
            end

            is_last = (cur_mode == MODE_SINGLE) ||
                      (cur_mode == MODE_BURST && idx_new == cur_last);

            if (end_pulse) begin
                pulse_next = 1'b0;
                if (is_last) begin
                    state_next   = ST_IDLE;
                    running_next = 1'b0;
                    done_next    = 1'b1;
                end else begin
                    state_next = ST_LOW;
                    timer_load = 1'b1;
                    timer_val  = cur_low;
                end
            end

            idx_next = idx_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pulse_reg   <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            idx_reg     <= '0;
            width_reg   <= '0;
            low_reg     <= '0;
            last_reg    <= '0;
            mode_reg    <= MODE_SINGLE;
        end else begin
            state_reg   <= state_next;
            pulse_reg   <= pulse_next;
            running_reg <= running_next;
            done_reg    <= done_next;
            idx_reg     <= idx_next;
            width_reg   <= width_next;
            low_reg     <= low_next;
            last_reg    <= last_next;
            mode_reg    <= mode_next;
        end
    end

    assign pulse_out = pulse_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign pulse_idx = idx_reg;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen. Edge numbers count rising clock edges;
// a "cycle N" high in the datasheet sense is the interval after edge N-1.
module tb_pulse_burst_gen;

    localparam int CW = 32;
    localparam int NW = 16;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger_in = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] delay = '0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] period = '0;
    logic [NW-1:0] count = '0;
    logic [1:0]    mode = 2'b00;
    logic          pulse_out;
    logic          running;
    logic          done;
    logic [NW-1:0] pulse_idx;

    pulse_burst_gen #(.CW(CW), .NW(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger_in (trigger_in),
        .abort      (abort),
        .delay      (delay),
        .width      (width),
        .period     (period),
        .count      (count),
        .mode       (mode),
        .pulse_out  (pulse_out),
        .running    (running),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int edge_n;
        int idx;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    logic prev_pulse = 1'b0;

    function automatic string kname(int k);
        return (k == K_RISE) ? "rise" : (k == K_FALL) ? "fall" : "done";
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(int kind, int e, int idx);
        ev_t ev;
        ev.kind = kind;
        ev.edge_n = e;
        ev.idx = idx;
        exp_q.push_back(ev);
    endtask

    // Pulse k rises on edge e0+d+k*pe and falls on edge e0+d+k*pe+w;
    // done follows the last pulse's fall edge.
    task automatic push_seq(int e0, int d, int w, int pe, int n, bit with_done);
        for (int k = 0; k < n; k++) begin
            if (w > 0) begin
                push_ev(K_RISE, e0 + d + k * pe, k);
                push_ev(K_FALL, e0 + d + k * pe + w, k);
            end
        end
        if (with_done) push_ev(K_DONE, e0 + d + (n - 1) * pe + w, n - 1);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (edge %0d)", name, act, cyc);
        end
    endtask

    task automatic start(logic [1:0] m, int d, int w, int p, int c, output int e0);
        mode = m;
        delay = CW'(d);
        width = CW'(w);
        period = CW'(p);
        count = NW'(c);
        trigger_in = 1'b1;
        e0 = cyc + 1;
        tick(1);
        trigger_in = 1'b0;
    endtask

    task automatic mon_event(int kind, int idx);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s at edge %0d idx=%0d, expected no event", kname(kind), cyc, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.edge_n != cyc ||
                (kind != K_FALL && e.idx != idx) ||
                (kind == K_DONE && running !== 1'b0)) begin
                miscompares++;
                $display("FAIL event: got %s edge=%0d idx=%0d running=%0b, expected %s edge=%0d idx=%0d",
                         kname(kind), cyc, idx, running, kname(e.kind), e.edge_n, e.idx);
            end else begin
                $display("ok   event %s edge=%0d idx=%0d", kname(kind), cyc, idx);
            end
        end
    endtask

    always @(negedge clk) begin
        if (pulse_out !== prev_pulse) mon_event(pulse_out ? K_RISE : K_FALL, int'(pulse_idx));
        if (done === 1'b1) mon_event(K_DONE, int'(pulse_idx));
        prev_pulse = pulse_out;
    end

    initial begin
        int e0;
        int e1;

        tick(3);
        check("reset pulse_out", 64'(pulse_out), 0);
        check("reset running", 64'(running), 0);
        check("reset done", 64'(done), 0);
        check("reset pulse_idx", 64'(pulse_idx), 0);
        rst = 1'b0;
        tick(2);

        // SINGLE, D=3, W=2
        start(2'b00, 3, 2, 0, 0, e0);
        push_seq(e0, 3, 2, 0, 1, 1'b1);
        check("t1 running after accept", 64'(running), 1);
        tick(10);
        check("t1 queue drained", 64'(exp_q.size()), 0);

        // BURST, D=0, W=2, P=5, count=3
        start(2'b01, 0, 2, 5, 3, e0);
        push_seq(e0, 0, 2, 5, 3, 1'b1);
        tick(18);
        check("t2 queue drained", 64'(exp_q.size()), 0);

        // BURST, W=4, P=3 -> Pe=5, one low cycle
        start(2'b01, 1, 4, 3, 2, e0);
        push_seq(e0, 1, 4, 5, 2, 1'b1);
        tick(16);
        check("t3 queue drained", 64'(exp_q.size()), 0);

        // BURST count=0 -> one pulse
        start(2'b01, 2, 3, 0, 0, e0);
        push_seq(e0, 2, 3, 4, 1, 1'b1);
        tick(10);
        check("t3b queue drained", 64'(exp_q.size()), 0);

        // BURST W=0, P=3, count=2: no pulses, done after second slot
        start(2'b01, 0, 0, 3, 2, e0);
        push_ev(K_DONE, e0 + 3, 1);
        tick(8);
        check("w0 queue drained", 64'(exp_q.size()), 0);

        // CONTINUOUS, W=1, P=2, abort once 10 pulses have completed
        start(2'b10, 0, 1, 2, 0, e0);
        push_seq(e0, 0, 1, 2, 10, 1'b0);
        tick(19);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4 pulse_out after abort", 64'(pulse_out), 0);
        check("t4 running after abort", 64'(running), 0);
        check("t4 done after abort", 64'(done), 0);
        check("t4 pulse_idx after abort", 64'(pulse_idx), 9);
        tick(6);
        check("t4 queue drained", 64'(exp_q.size()), 0);

        // abort beats trigger in IDLE
        mode = 2'b00;
        delay = '0;
        width = CW'(2);
        trigger_in = 1'b1;
        abort = 1'b1;
        tick(1);
        trigger_in = 1'b0;
        abort = 1'b0;
        check("abort+trigger running", 64'(running), 0);
        check("abort+trigger pulse_out", 64'(pulse_out), 0);
        tick(4);

        // GATED, W=2, P=4, trigger sampled high on 9 edges
        mode = 2'b11;
        delay = '0;
        width = CW'(2);
        period = CW'(4);
        count = '0;
        trigger_in = 1'b1;
        e0 = cyc + 1;
        push_seq(e0, 0, 2, 4, 3, 1'b0);
        push_ev(K_DONE, e0 + 12, 2);
        tick(9);
        trigger_in = 1'b0;
        tick(4);
        check("t5 done strobe", 64'(done), 1);
        trigger_in = 1'b1;
        e1 = cyc + 1;
        push_ev(K_RISE, e1, 0);
        push_ev(K_FALL, e1 + 2, 0);
        push_ev(K_DONE, e1 + 4, 0);
        tick(1);
        trigger_in = 1'b0;
        check("t5 retrigger running", 64'(running), 1);
        tick(8);
        check("t5 queue drained", 64'(exp_q.size()), 0);

        // Inputs changed mid-burst must not disturb timing
        start(2'b01, 2, 3, 6, 3, e0);
        push_seq(e0, 2, 3, 6, 3, 1'b1);
        delay = CW'(7);
        width = CW'(1);
        period = CW'(2);
        count = NW'(9);
        mode = 2'b10;
        tick(22);
        check("t6 queue drained", 64'(exp_q.size()), 0);

        // rst during HIGH of pulse 1
        start(2'b01, 2, 3, 6, 3, e0);
        push_ev(K_RISE, e0 + 2, 0);
        push_ev(K_FALL, e0 + 5, 0);
        push_ev(K_RISE, e0 + 8, 1);
        push_ev(K_FALL, e0 + 9, 1);
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6 rst pulse_out", 64'(pulse_out), 0);
        check("t6 rst running", 64'(running), 0);
        check("t6 rst done", 64'(done), 0);
        check("t6 rst pulse_idx", 64'(pulse_idx), 0);
        tick(10);
        check("t6 rst queue drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
